pcx2mb_fsl_drain: RTL and testbench



---
 rtl/pcx2mb_fsl_drain_if.sv | 22 ++
 rtl/pcx2mb_fsl_drain.sv | 114 +++++++++++
 tb/tb_pcx2mb_fsl_drain.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pcx2mb_fsl_drain_if.sv
// FSL master-side bus between the PCX drain stage and the MicroBlaze FSL FIFO.
// The drain drives data/control/write; the FIFO side returns full.
interface pcx2mb_fsl_drain_if;
  logic [31:0] fsl_m_data;
  logic        fsl_m_control;
  logic        fsl_m_write;
  logic        fsl_m_full;

  modport master (
    output fsl_m_data,
    output fsl_m_control,
    output fsl_m_write,
    input  fsl_m_full
  );

  modport slave (
    input  fsl_m_data,
    input  fsl_m_control,
    input  fsl_m_write,
    output fsl_m_full
  );
endinterface

// File: rtl/pcx2mb_fsl_drain.sv
// Drains the head PCX buffer entry onto the FSL master port, MSW first, then retires it.
// Optional macro PCX2MB_FSL_PARITY_EN puts odd parity over head_data into frame bit 127.
module pcx2mb_fsl_drain #(
  parameter int PCX_WIDTH     = 124,
  parameter int PCX_REQ_WIDTH = 2,
  parameter int NWORDS        = 4,
  localparam int EW           = PCX_WIDTH + PCX_REQ_WIDTH + 1
) (
  input  logic                 rclk,
  input  logic                 reset,
  input  logic [EW-1:0]        head_data,
  input  logic                 head_active,
  output logic                 load_data,
  output logic                 drain_busy,
  output logic [15:0]          pkt_count,
  pcx2mb_fsl_drain_if.master   fsl
);

  localparam int FW   = NWORDS * 32;
  localparam int PADW = FW - EW;
  localparam int IW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RETIRE
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [15:0]     pkt_count_q, pkt_count_d;
  logic [FW-1:0]   frame_in;
  logic [31:0]     word_sel;

  // Pad bits above the entry are zero unless the parity option claims the top bit.
  always_comb begin
    frame_in = {{PADW{1'b0}}, head_data};
`ifdef PCX2MB_FSL_PARITY_EN
    frame_in[FW-1] = ~^head_data;
`endif
  end

  always_comb begin
    word_sel = '0;
    for (int w = 0; w < NWORDS; w++) begin
      if (idx_q == IW'(w)) begin
        word_sel = frame_q[(NWORDS-1-w)*32 +: 32];
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      idx_q       <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      idx_q       <= idx_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  // Write strobe follows full combinationally so a stalled word is re-offered every cycle.
  always_comb begin
    state_d           = state_q;
    frame_d           = frame_q;
    idx_d             = idx_q;
    pkt_count_d       = pkt_count_q;
    load_data         = 1'b0;
    fsl.fsl_m_data    = 32'h0;
    fsl.fsl_m_control = 1'b0;
    fsl.fsl_m_write   = 1'b0;

    case (state_q)
      IDLE: begin
        if (head_active) begin
          frame_d = frame_in;
          idx_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        fsl.fsl_m_data    = word_sel;
        fsl.fsl_m_control = (idx_q == '0);
        fsl.fsl_m_write   = !fsl.fsl_m_full;
        if (!fsl.fsl_m_full) begin
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(NWORDS-1)) begin
            state_d = RETIRE;
          end
        end
      end

      RETIRE: begin
        load_data   = 1'b1;
        pkt_count_d = pkt_count_q + 16'd1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign drain_busy = (state_q != IDLE);
  assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_pcx2mb_fsl_drain.sv
// Directed self-checking bench for pcx2mb_fsl_drain: framing, backpressure, back-to-back,
// mid-packet reset, counter wrap and the pad/parity bit.
module tb_pcx2mb_fsl_drain;

  logic         rclk = 1'b0;
  logic         reset;
  logic         head_active;
  logic [126:0] head_data;
  logic         load_data;
  logic         drain_busy;
  logic [15:0]  pkt_count;
  int           compared = 0;
  int           mismatched = 0;

  localparam logic [127:0] PAT_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] PAT_B = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
  localparam logic [127:0] PAT_C = 128'h5555_5555_6666_6666_7777_7777_0888_8888;

`ifdef PCX2MB_FSL_PARITY_EN
  localparam logic [31:0] ZERO_FIRST = 32'h8000_0000;
`else
  localparam logic [31:0] ZERO_FIRST = 32'h0000_0000;
`endif

  logic [31:0] wordsA [4];
  logic [31:0] wordsAll [12];

  pcx2mb_fsl_drain_if fslIf ();

  pcx2mb_fsl_drain dut (
    .rclk        (rclk),
    .reset       (reset),
    .head_data   (head_data),
    .head_active (head_active),
    .load_data   (load_data),
    .drain_busy  (drain_busy),
    .pkt_count   (pkt_count),
    .fsl         (fslIf.master)
  );

  always #5 rclk = ~rclk;

  task automatic present(input logic [127:0] pat, input logic act);
    head_data   = pat[126:0];
    head_active = act;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    head_active = 1'b0;
    head_data = '0;
    fslIf.fsl_m_full = 1'b0;
    repeat (2) @(negedge rclk);
    #1;
    compared++; if (load_data !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_load: got %b expected 0", load_data); end
    compared++; if (fslIf.fsl_m_write !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_write: got %b expected 0", fslIf.fsl_m_write); end
    compared++; if (fslIf.fsl_m_control !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_control: got %b expected 0", fslIf.fsl_m_control); end
    compared++; if (fslIf.fsl_m_data !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_data: got %h expected 00000000", fslIf.fsl_m_data); end
    compared++; if (drain_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", drain_busy); end
    compared++; if (pkt_count !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_count: got %h expected 0000", pkt_count); end
    @(negedge rclk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    @(negedge rclk);
    present(PAT_A, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge rclk);
      if (c == 1) present({128{1'b1}}, 1'b0);
      #1;
      if (c <= 4) begin
        compared++; if (fslIf.fsl_m_write !== 1'b1) begin mismatched++; $display("[TB] FAIL single_write c%0d: got %b expected 1", c, fslIf.fsl_m_write); end
        compared++; if (fslIf.fsl_m_data !== wordsA[c-1]) begin mismatched++; $display("[TB] FAIL single_data c%0d: got %h expected %h", c, fslIf.fsl_m_data, wordsA[c-1]); end
        compared++; if (fslIf.fsl_m_control !== (c == 1)) begin mismatched++; $display("[TB] FAIL single_control c%0d: got %b expected %b", c, fslIf.fsl_m_control, (c == 1)); end
        compared++; if (load_data !== 1'b0) begin mismatched++; $display("[TB] FAIL single_early_load c%0d: got %b expected 0", c, load_data); end
      end else if (c == 5) begin
        compared++; if (load_data !== 1'b1) begin mismatched++; $display("[TB] FAIL single_load: got %b expected 1", load_data); end
        compared++; if (fslIf.fsl_m_write !== 1'b0) begin mismatched++; $display("[TB] FAIL single_retire_write: got %b expected 0", fslIf.fsl_m_write); end
        compared++; if (drain_busy !== 1'b1) begin mismatched++; $display("[TB] FAIL single_retire_busy: got %b expected 1", drain_busy); end
        compared++; if (pkt_count !== 16'd0) begin mismatched++; $display("[TB] FAIL single_count_pre: got %0d expected 0", pkt_count); end
      end else begin
        compared++; if (load_data !== 1'b0) begin mismatched++; $display("[TB] FAIL single_load_end: got %b expected 0", load_data); end
        compared++; if (drain_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL single_idle_busy: got %b expected 0", drain_busy); end
        compared++; if (pkt_count !== 16'd1) begin mismatched++; $display("[TB] FAIL single_count: got %0d expected 1", pkt_count); end
      end
    end
  endtask

  task automatic test_backpressure();
    int expIdx [9] = '{0, 1, 2, 2, 2, 2, 3, 0, 0};
    logic expWr [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int writes = 0;
    @(negedge rclk);
    present(PAT_A, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge rclk);
      if (c == 1) present(PAT_B, 1'b0);
      fslIf.fsl_m_full = (c >= 3 && c <= 5);
      #1;
      if (fslIf.fsl_m_write === 1'b1) writes++;
      compared++; if (fslIf.fsl_m_write !== expWr[c-1]) begin mismatched++; $display("[TB] FAIL bp_write c%0d: got %b expected %b", c, fslIf.fsl_m_write, expWr[c-1]); end
      if (c <= 7) begin
        compared++; if (fslIf.fsl_m_data !== wordsA[expIdx[c-1]]) begin mismatched++; $display("[TB] FAIL bp_data c%0d: got %h expected %h", c, fslIf.fsl_m_data, wordsA[expIdx[c-1]]); end
        compared++; if (fslIf.fsl_m_control !== (c == 1)) begin mismatched++; $display("[TB] FAIL bp_control c%0d: got %b expected %b", c, fslIf.fsl_m_control, (c == 1)); end
      end
      compared++; if (load_data !== (c == 8)) begin mismatched++; $display("[TB] FAIL bp_load c%0d: got %b expected %b", c, load_data, (c == 8)); end
    end
    fslIf.fsl_m_full = 1'b0;
    compared++; if (writes !== 4) begin mismatched++; $display("[TB] FAIL bp_write_total: got %0d expected 4", writes); end
    compared++; if (pkt_count !== 16'd2) begin mismatched++; $display("[TB] FAIL bp_count: got %0d expected 2", pkt_count); end
  endtask

  task automatic test_back_to_back();
    int wr = 0;
    int ctrls = 0;
    int loads = 0;
    int loadCyc [3] = '{0, 0, 0};
    for (int c = 0; c <= 19; c++) begin
      @(negedge rclk);
      if (c < 6) present(PAT_A, 1'b1);
      else if (c < 12) present(PAT_B, 1'b1);
      else present(PAT_C, (c == 12));
      #1;
      if (fslIf.fsl_m_write === 1'b1) begin
        if (wr < 12) begin
          compared++; if (fslIf.fsl_m_data !== wordsAll[wr]) begin mismatched++; $display("[TB] FAIL b2b_data w%0d: got %h expected %h", wr, fslIf.fsl_m_data, wordsAll[wr]); end
          compared++; if (fslIf.fsl_m_control !== (wr % 4 == 0)) begin mismatched++; $display("[TB] FAIL b2b_control w%0d: got %b expected %b", wr, fslIf.fsl_m_control, (wr % 4 == 0)); end
        end
        if (fslIf.fsl_m_control === 1'b1) ctrls++;
        wr++;
      end
      if (load_data === 1'b1) begin
        if (loads < 3) loadCyc[loads] = c;
        loads++;
      end
    end
    compared++; if (wr !== 12) begin mismatched++; $display("[TB] FAIL b2b_writes: got %0d expected 12", wr); end
    compared++; if (ctrls !== 3) begin mismatched++; $display("[TB] FAIL b2b_controls: got %0d expected 3", ctrls); end
    compared++; if (loads !== 3) begin mismatched++; $display("[TB] FAIL b2b_loads: got %0d expected 3", loads); end
    compared++; if (loadCyc[0] !== 5) begin mismatched++; $display("[TB] FAIL b2b_first_load: got %0d expected 5", loadCyc[0]); end
    compared++; if (loadCyc[1] - loadCyc[0] !== 6) begin mismatched++; $display("[TB] FAIL b2b_spacing1: got %0d expected 6", loadCyc[1] - loadCyc[0]); end
    compared++; if (loadCyc[2] - loadCyc[1] !== 6) begin mismatched++; $display("[TB] FAIL b2b_spacing2: got %0d expected 6", loadCyc[2] - loadCyc[1]); end
    compared++; if (pkt_count !== 16'd5) begin mismatched++; $display("[TB] FAIL b2b_count: got %0d expected 5", pkt_count); end
  endtask

  task automatic test_reset_mid();
    @(negedge rclk);
    present(PAT_A, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      @(negedge rclk);
      reset = (c == 3 || c == 4);
      if (c == 6) head_active = 1'b0;
      #1;
      if (c == 2) begin
        compared++; if (fslIf.fsl_m_data !== wordsA[1]) begin mismatched++; $display("[TB] FAIL mid_word1: got %h expected %h", fslIf.fsl_m_data, wordsA[1]); end
      end
      if (c == 4) begin
        compared++; if (fslIf.fsl_m_write !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_write: got %b expected 0", fslIf.fsl_m_write); end
        compared++; if (fslIf.fsl_m_control !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_control: got %b expected 0", fslIf.fsl_m_control); end
        compared++; if (fslIf.fsl_m_data !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_data: got %h expected 00000000", fslIf.fsl_m_data); end
        compared++; if (drain_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_busy: got %b expected 0", drain_busy); end
        compared++; if (pkt_count !== 16'd0) begin mismatched++; $display("[TB] FAIL mid_count: got %0d expected 0", pkt_count); end
      end
      if (c >= 6 && c <= 9) begin
        compared++; if (fslIf.fsl_m_data !== wordsA[c-6]) begin mismatched++; $display("[TB] FAIL mid_resend c%0d: got %h expected %h", c, fslIf.fsl_m_data, wordsA[c-6]); end
        compared++; if (fslIf.fsl_m_control !== (c == 6)) begin mismatched++; $display("[TB] FAIL mid_resend_ctrl c%0d: got %b expected %b", c, fslIf.fsl_m_control, (c == 6)); end
      end
      compared++; if (load_data !== (c == 10)) begin mismatched++; $display("[TB] FAIL mid_load c%0d: got %b expected %b", c, load_data, (c == 10)); end
    end
    compared++; if (pkt_count !== 16'd1) begin mismatched++; $display("[TB] FAIL mid_count_after: got %0d expected 1", pkt_count); end
  endtask

  task automatic test_wrap();
    @(negedge rclk);
    force dut.pkt_count_q = 16'hFFFF;
    @(negedge rclk);
    release dut.pkt_count_q;
    #1;
    compared++; if (pkt_count !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL wrap_preload: got %h expected ffff", pkt_count); end
    present(PAT_B, 1'b1);
    @(negedge rclk);
    head_active = 1'b0;
    repeat (5) @(negedge rclk);
    #1;
    compared++; if (pkt_count !== 16'h0000) begin mismatched++; $display("[TB] FAIL wrap_count: got %h expected 0000", pkt_count); end
  endtask

  task automatic test_pad_bit();
    @(negedge rclk);
    present('0, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge rclk);
      if (c == 1) head_active = 1'b0;
      #1;
      if (c == 1) begin
        compared++; if (fslIf.fsl_m_data !== ZERO_FIRST) begin mismatched++; $display("[TB] FAIL pad_first: got %h expected %h", fslIf.fsl_m_data, ZERO_FIRST); end
      end else if (c <= 4) begin
        compared++; if (fslIf.fsl_m_data !== 32'h0) begin mismatched++; $display("[TB] FAIL pad_word c%0d: got %h expected 00000000", c, fslIf.fsl_m_data); end
      end
      compared++; if (load_data !== (c == 5)) begin mismatched++; $display("[TB] FAIL pad_load c%0d: got %b expected %b", c, load_data, (c == 5)); end
    end
  endtask

  initial begin
    wordsA = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210};
    wordsAll = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210,
                 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                 32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h0888_8888};
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_pad_bit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
